mmm_result_shreg: RTL
=====================

Name: mmm_result_shreg

Overview:
Parametrised successor to the 10-bit Montgomery partial-result register in the RSA datapath. It holds the running result R_i of the modular-multiply loop and selects between a locked result (reg_rji), a fresh operand (a), right-shift by one (divide-by-2 step with carry-in), a synchronous loop clear, or hold. An iteration counter tracks shift steps and flags completion, so the MMM controller no longer counts bits externally.

Parameters:
WIDTH, 10, datapath width of R_i, reg_rji and a (legal range 2..64)
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  step enable; gates ld_r and shr operations
clr  input  1  synchronous loop clear (replaces rst_mmm_i); acts regardless of en
lock  input  1  with ld_r, selects reg_rji as load source
ld_r  input  1  load request
shr  input  1  shift-right request
sin  input  1  bit shifted into MSB on shr
reg_rji  input  WIDTH  locked-result load source
a  input  WIDTH  operand load source
r_o  output  WIDTH  current R_i register
sout  output  1  r_o[0], combinational from the register (bit leaving on next shr)
cnt  output  CNT_W  shift steps taken since last load/clear
done  output  1  high when cnt == WIDTH
shift_err  output  1  one-cycle pulse: shr accepted while done

Behaviour:
- Reset (rst=1, async): r_o=0, cnt=0, shift_err=0; done=0, sout=0 follow. Release is synchronous to the next rising clk edge.
- Per rising clk edge, strict priority:
  1. clr=1: r_o<=0, cnt<=0, shift_err<=0. Independent of en and of all other inputs.
  2. en=0: r_o and cnt hold; shift_err<=0.
  3. en=1, ld_r=1, lock=1: r_o<=reg_rji; cnt<=0.
  4. en=1, ld_r=1, lock=0: r_o<=a; cnt<=0.
  5. en=1, shr=1, done=0: r_o<={sin, r_o[WIDTH-1:1]}; cnt<=cnt+1.
  6. en=1, shr=1, done=1: r_o and cnt hold; shift_err<=1 for this cycle only.
  7. Otherwise: hold.
- ld_r has priority over shr when both are asserted; the load wins and cnt restarts at 0.
- lock is ignored unless ld_r=1.
- shift_err is registered. It is 0 in every cycle not covered by case 6.
- done = (cnt == WIDTH), combinational from cnt. cnt saturates at WIDTH and never wraps.
- sout = r_o[0], combinational; no added latency.
- All register updates take effect one cycle after the qualifying edge; there is no other pipelining.
- Reset asserted mid-loop clears everything immediately; no partial state survives.

Test Plan:
- Reset: assert rst with r_o=0x3FF and cnt=5 (WIDTH=10) -> r_o=0, cnt=0, done=0, shift_err=0 asynchronously, before any clk edge.
- Load priority: en=1, ld_r=1, lock=1, reg_rji=0x2A5, a=0x15A -> r_o=0x2A5. Next cycle lock=0 -> r_o=0x15A. Both loads leave cnt=0.
- Shift sequence: load a=0x001, then 10 edges with en=1, shr=1, sin=1 -> sout=1 before the first shift. r_o=0x3FF after 10 shifts. cnt steps 1..10 and done rises on the 10th shift.
- Overshift: after the previous test, apply one more shr -> r_o stays 0x3FF, cnt stays 10, shift_err high for exactly 1 cycle.
- clr beats en: en=0, clr=1 with r_o=0x155 -> r_o=0, cnt=0 on the next edge. Same result with en=1, ld_r=1 asserted together with clr.
- Simultaneous ld_r and shr at cnt=4: en=1, ld_r=1, lock=0, shr=1, a=0x0F0 -> r_o=0x0F0, cnt=0, no shift, shift_err=0. Repeat with WIDTH=16: 16 shifts raise done.

Source files
------------

// File: rtl/mmm_result_shreg.sv
// rtl/mmm_result_shreg.sv - Montgomery partial-result shift register with iteration counter
// Holds R_i: load locked result or operand, divide-by-2 shift with carry-in, clear, hold.
module mmm_result_shreg #(
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             lock,
  input  logic             ld_r,
  input  logic             shr,
  input  logic             sin,
  input  logic [WIDTH-1:0] reg_rji,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] r_o,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             shift_err
);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             done_w;

  assign done_w = (cnt_q == CNT_W'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      r_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (en) begin
        if (ld_r) begin
          r_q   <= lock ? reg_rji : a;
          cnt_q <= '0;
        end else if (shr) begin
          // Once all WIDTH steps are taken the register freezes; an extra shift is flagged.
          if (!done_w) begin
            r_q   <= {sin, r_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign r_o       = r_q;
  assign sout      = r_q[0];
  assign cnt       = cnt_q;
  assign done      = done_w;
  assign shift_err = err_q;

endmodule
